// File: rtl/bb_traverser.sv
// Bounding-box pixel sequencer: walks [left,right) x [top,bottom) one pixel per cycle.
// Define BB_TRAVERSER_SERPENTINE_EN for alternating row direction; default is raster order.
module bb_traverser #(
    parameter int COORD_W = 32,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bb_valid,
    output logic               bb_ready,
    input  logic [COORD_W-1:0] bb_left,
    input  logic [COORD_W-1:0] bb_right,
    input  logic [COORD_W-1:0] bb_top,
    input  logic [COORD_W-1:0] bb_bottom,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic               tri_done,
    output logic [CNT_W-1:0]   pix_count,
    output logic               busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [COORD_W:0]   ONE_W = {{COORD_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   ONE_N = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic [COORD_W-1:0] left_q, left_d;
    logic [COORD_W-1:0] right_q, right_d;
    logic [COORD_W-1:0] bottom_q, bottom_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d;
    logic [COORD_W-1:0] pix_y_q, pix_y_d;
    logic               pix_valid_q, pix_valid_d;
    logic               pix_last_q, pix_last_d;
    logic               tri_done_q, tri_done_d;
    logic [CNT_W-1:0]   pix_count_q, pix_count_d;
    logic               busy_q, busy_d;
`ifdef BB_TRAVERSER_SERPENTINE_EN
    localparam logic [COORD_W-1:0] ONE_C = {{(COORD_W-1){1'b0}}, 1'b1};
    logic               dir_q, dir_d;
`endif

    // Next-pixel coordinates, all increments carried at COORD_W+1 bits so max bounds never wrap
    logic [COORD_W:0]   x_inc;
    logic [COORD_W:0]   y_inc;
    logic [COORD_W-1:0] nx;
    logic [COORD_W-1:0] ny;
    logic               nlast;

    always_comb begin
        x_inc = {1'b0, pix_x_q} + ONE_W;
        y_inc = {1'b0, pix_y_q} + ONE_W;
        nx    = pix_x_q;
        ny    = pix_y_q;
`ifdef BB_TRAVERSER_SERPENTINE_EN
        dir_d = dir_q;
        if (!dir_q) begin
            if (x_inc < {1'b0, right_q}) begin
                nx = x_inc[COORD_W-1:0];
            end else begin
                ny    = y_inc[COORD_W-1:0];
                dir_d = 1'b1;
            end
        end else begin
            if (pix_x_q > left_q) begin
                nx = pix_x_q - ONE_C;
            end else begin
                ny    = y_inc[COORD_W-1:0];
                dir_d = 1'b0;
            end
        end
        // Final row ends at right-1 when scanned forward, at left when scanned backward
        nlast = (({1'b0, ny} + ONE_W) == {1'b0, bottom_q}) &&
                (dir_d ? (nx == left_q) : (({1'b0, nx} + ONE_W) == {1'b0, right_q}));
`else
        if (x_inc < {1'b0, right_q}) begin
            nx = x_inc[COORD_W-1:0];
        end else begin
            nx = left_q;
            ny = y_inc[COORD_W-1:0];
        end
        nlast = (({1'b0, ny} + ONE_W) == {1'b0, bottom_q}) &&
                (({1'b0, nx} + ONE_W) == {1'b0, right_q});
`endif
    end

    always_comb begin
        state_d     = state_q;
        left_d      = left_q;
        right_d     = right_q;
        bottom_d    = bottom_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        pix_count_d = pix_count_q;
        case (state_q)
            ST_IDLE: begin
                if (bb_valid) begin
                    left_d      = bb_left;
                    right_d     = bb_right;
                    bottom_d    = bb_bottom;
                    pix_count_d = '0;
                    if ((bb_left < bb_right) && (bb_top < bb_bottom)) begin
                        state_d     = ST_SCAN;
                        pix_x_d     = bb_left;
                        pix_y_d     = bb_top;
                        pix_valid_d = 1'b1;
                        pix_last_d  = (({1'b0, bb_left} + ONE_W) == {1'b0, bb_right}) &&
                                      (({1'b0, bb_top} + ONE_W) == {1'b0, bb_bottom});
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SCAN: begin
                if (pix_valid_q && pix_ready) begin
                    pix_count_d = pix_count_q + ONE_N;
                    if (pix_last_q) begin
                        state_d     = ST_DONE;
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                    end else begin
                        pix_x_d    = nx;
                        pix_y_d    = ny;
                        pix_last_d = nlast;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tri_done_d = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE);
    end

`ifdef BB_TRAVERSER_SERPENTINE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            dir_q <= 1'b0;
        end else if (state_q == ST_SCAN && pix_valid_q && pix_ready && !pix_last_q) begin
            dir_q <= dir_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            left_q      <= '0;
            right_q     <= '0;
            bottom_q    <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            tri_done_q  <= 1'b0;
            pix_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            left_q      <= left_d;
            right_q     <= right_d;
            bottom_q    <= bottom_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            tri_done_q  <= tri_done_d;
            pix_count_q <= pix_count_d;
            busy_q      <= busy_d;
        end
    end

    assign bb_ready  = (state_q == ST_IDLE);
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_last  = pix_last_q;
    assign tri_done  = tri_done_q;
    assign pix_count = pix_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bb_traverser.sv
// Randomized bench for bb_traverser against a queue-based pixel-order model.
module tb_bb_traverser;

    logic        clk = 1'b0;
    logic        rst;
    logic        bb_valid;
    logic        bb_ready;
    logic [31:0] bb_left, bb_right, bb_top, bb_bottom;
    logic        pix_valid;
    logic        pix_ready;
    logic [31:0] pix_x, pix_y;
    logic        pix_last;
    logic        tri_done;
    logic [31:0] pix_count;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    longint unsigned exp_x[$];
    longint unsigned exp_y[$];

    always #5 clk = ~clk;

    bb_traverser #(.COORD_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .bb_valid(bb_valid), .bb_ready(bb_ready),
        .bb_left(bb_left), .bb_right(bb_right), .bb_top(bb_top), .bb_bottom(bb_bottom),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
        .tri_done(tri_done), .pix_count(pix_count), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected pixel order straight from the box definition
    task automatic build_expected(input longint unsigned l, input longint unsigned r,
                                  input longint unsigned t, input longint unsigned b);
        exp_x.delete();
        exp_y.delete();
        if (l < r && t < b) begin
            for (longint unsigned y = t; y < b; y++) begin
                for (longint unsigned i = 0; i < r - l; i++) begin
`ifdef BB_TRAVERSER_SERPENTINE_EN
                    exp_x.push_back(((y - t) % 2 == 1) ? (r - 1 - i) : (l + i));
`else
                    exp_x.push_back(l + i);
`endif
                    exp_y.push_back(y);
                end
            end
        end
    endtask

    task automatic accept_box(input logic [31:0] l, input logic [31:0] r,
                              input logic [31:0] t, input logic [31:0] b);
        int wc = 0;
        while (!bb_ready && wc < 100) begin
            step();
            wc++;
        end
        check("bb_ready_idle", bb_ready, 1);
        build_expected(l, r, t, b);
        bb_valid  = 1'b1;
        bb_left   = l;
        bb_right  = r;
        bb_top    = t;
        bb_bottom = b;
        step();
        bb_valid  = 1'b0;
        bb_left   = $urandom;
        bb_right  = $urandom;
        bb_top    = $urandom;
        bb_bottom = $urandom;
        check("busy_after_accept", busy, 1);
        check("count_cleared", pix_count, 0);
    endtask

    // mode 0: always ready, 1: random, 2: pattern bits LSB-first then ready
    task automatic run_box(input logic [31:0] l, input logic [31:0] r,
                           input logic [31:0] t, input logic [31:0] b,
                           input int mode, input logic [31:0] pat);
        int len;
        int idx = 0;
        int cyc = 0;
        int budget;
        logic rdy;
        accept_box(l, r, t, b);
        len    = exp_x.size();
        budget = len * 30 + 50;
        while (idx < len && cyc < budget) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc < 32) ? pat[cyc] : 1'b1;
            endcase
            pix_ready = rdy;
            check("pix_valid", pix_valid, 1);
            check("pix_x", pix_x, exp_x[idx]);
            check("pix_y", pix_y, exp_y[idx]);
            check("pix_last", pix_last, (idx == len - 1) ? 1 : 0);
            check("tri_done_scan", tri_done, 0);
            check("pix_count_scan", pix_count, idx);
            if (rdy) idx++;
            step();
            cyc++;
        end
        if (idx < len) check("scan_timeout", idx, len);
        pix_ready = 1'($urandom_range(0, 1));
        check("done_tri_done", tri_done, 1);
        check("done_pix_valid", pix_valid, 0);
        check("done_bb_ready", bb_ready, 0);
        check("done_busy", busy, 1);
        check("done_count", pix_count, len);
        step();
        check("idle_tri_done", tri_done, 0);
        check("idle_bb_ready", bb_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_count_held", pix_count, len);
    endtask

    task automatic reset_mid_scan(input logic [31:0] l, input logic [31:0] t);
        accept_box(l, l + 4, t, t + 4);
        pix_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_pre_x", pix_x, exp_x[i]);
            check("rst_pre_y", pix_y, exp_y[i]);
            step();
        end
        rst = 1'b1;
        #1;
        check("arst_pix_valid", pix_valid, 0);
        check("arst_pix_x", pix_x, 0);
        check("arst_pix_y", pix_y, 0);
        check("arst_pix_last", pix_last, 0);
        check("arst_count", pix_count, 0);
        check("arst_busy", busy, 0);
        check("arst_bb_ready", bb_ready, 1);
        check("arst_tri_done", tri_done, 0);
        #2;
        rst = 1'b0;
        step();
        check("post_rst_tri_done", tri_done, 0);
        check("post_rst_valid", pix_valid, 0);
        check("post_rst_bb_ready", bb_ready, 1);
    endtask

    initial begin
        logic [31:0] w, h, l, r, t, b, tmp;
        rst       = 1'b1;
        bb_valid  = 1'b0;
        bb_left   = '0;
        bb_right  = '0;
        bb_top    = '0;
        bb_bottom = '0;
        pix_ready = 1'b0;
        #2;
        check("reset_bb_ready", bb_ready, 1);
        check("reset_pix_valid", pix_valid, 0);
        check("reset_pix_x", pix_x, 0);
        check("reset_pix_y", pix_y, 0);
        check("reset_pix_last", pix_last, 0);
        check("reset_tri_done", tri_done, 0);
        check("reset_pix_count", pix_count, 0);
        check("reset_busy", busy, 0);
        #20;
        rst = 1'b0;
        step();

        run_box(4, 6, 10, 12, 0, 0);
        run_box(7, 7, 5, 9, 0, 0);
        run_box(0, 4, 5, 3, 0, 0);
        run_box(0, 3, 0, 1, 2, 32'h0000_0019);
        run_box(1919, 1920, 1079, 1080, 0, 0);
        run_box(0, 3, 0, 2, 0, 0);
        run_box(0, 3, 0, 3, 1, 0);
        run_box(32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1, 0);
        reset_mid_scan(2, 5);
        run_box(10, 13, 20, 22, 0, 0);

        for (int n = 0; n < 40; n++) begin
            w = $urandom_range(0, 5);
            h = $urandom_range(0, 4);
            l = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - w) : $urandom_range(0, 100000);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - h) : $urandom_range(0, 100000);
            r = l + w;
            b = t + h;
            if ($urandom_range(0, 7) == 0) begin
                tmp = l;
                l   = r;
                r   = tmp;
            end
            run_box(l, r, t, b, 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bb_traverser.md
Name: bb_traverser

Overview:
- Sequencer downstream of the bounding-box generator. Accepts one clamped triangle bounding box (Left/Right/Top/Bottom, integer pixels) per handshake.
- Walks every candidate pixel in raster order and emits one (x,y) per cycle over a valid/ready stream to the edge-function/fragment stage.
- Reports a per-triangle completion pulse and pixel count, so the upstream setup stage can issue the next triangle.

Parameters:
- COORD_W, 32, width of every coordinate and bound (matches the bounding-box generator's outputs).
- CNT_W, 32, width of the per-triangle pixel counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- bb_valid  input  1  bounding box presented.
- bb_ready  output  1  traverser can accept a box.
- bb_left  input  COORD_W  first column, inclusive.
- bb_right  input  COORD_W  column bound, exclusive.
- bb_top  input  COORD_W  first row, inclusive.
- bb_bottom  input  COORD_W  row bound, exclusive.
- pix_valid  output  1  pix_x/pix_y valid.
- pix_ready  input  1  consumer accepts pixel.
- pix_x  output  COORD_W  pixel column.
- pix_y  output  COORD_W  pixel row.
- pix_last  output  1  current pixel is final pixel of the box.
- tri_done  output  1  one-cycle pulse after a box finishes (including an empty box).
- pix_count  output  CNT_W  pixels handed off for the most recent or current box.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Asynchronous active-high reset, rst.
- Reset values:
  - State IDLE.
  - bb_ready=1.
  - pix_valid=0, pix_x=0, pix_y=0, pix_last=0.
  - tri_done=0, pix_count=0, busy=0.
- Outputs: all outputs are registered except bb_ready, which equals (state==IDLE).
- Bounds:
  - Comparisons are unsigned.
  - Bounds are half-open: x in [left,right), y in [top,bottom).
  - A box is empty if left>=right or top>=bottom.
- States: IDLE, SCAN, DONE.
- IDLE:
  - On bb_valid&&bb_ready, latch all four bounds and clear pix_count.
  - If the box is non-empty, go to SCAN. Next cycle: pix_valid=1, pix_x=left, pix_y=top, pix_last=(left+1==right && top+1==bottom). Latency from accept to first pixel is 1 cycle.
  - If the box is empty, go to DONE. No pixel is emitted.
- SCAN, handshake rules:
  - A pixel transfers on pix_valid&&pix_ready.
  - While pix_valid&&!pix_ready, pix_x, pix_y and pix_last hold stable.
  - pix_valid never drops without a transfer.
- SCAN, on each transfer:
  - pix_count increments.
  - If pix_x+1<right: pix_x increments.
  - Otherwise pix_x=left and pix_y increments.
  - pix_last is recomputed for the new pixel.
  - Sustained throughput is 1 pixel/cycle.
- SCAN, on the transfer with pix_last=1: pix_valid=0 next cycle, state to DONE.
- DONE: tri_done=1 for exactly one cycle, bb_ready=0, then IDLE. Minimum gap between boxes is therefore 1 cycle after the last pixel.
- pix_count: holds its final value until the next box is accepted.
- Arithmetic: x+1 and y+1 are computed at COORD_W+1 bits, so right or bottom = 2^COORD_W-1 never wraps.
- Boxes are not re-read after acceptance. Input changes while busy are ignored.
- rst mid-SCAN: all state returns to reset values immediately. No tri_done is generated. The in-flight pixel is dropped.

Optional Feature:
- Macro: BB_TRAVERSER_SERPENTINE_EN.
- Defined: rows alternate direction.
  - Even row index (relative to top) runs left→right-1.
  - Odd row index runs right-1→left.
  - At a row end, the next pixel's column is unchanged and y increments.
  - pix_last marks the final pixel of the final row under this ordering: column right-1 if the row count is odd, column left if even.
  - A direction register resets to left-to-right.
- Undefined: raster order only, no direction register.
- Pixel set, pix_count, handshake and latency are identical in both builds.

Test Plan:
- Box left=4,right=6,top=10,bottom=12, pix_ready=1 → pixels (4,10),(5,10),(4,11),(5,11) on 4 consecutive cycles. pix_last only on (5,11). tri_done 1 cycle later. pix_count=4.
- Empty boxes left=7,right=7 and top=5,bottom=3 → no pix_valid. tri_done one cycle after accept. pix_count=0. bb_ready back to 1 the following cycle.
- Box 0..3 x 0..1 with pix_ready toggled 1,0,0,1,1 → pix_x/pix_y stable during stalls. Sequence (0,0),(1,0),(2,0) delivered exactly once each.
- Single pixel left=1919,right=1920,top=1079,bottom=1080 → one pixel (1919,1079) with pix_last=1. Then tri_done.
- Assert rst after 3 transfers of a 4x4 box → outputs at reset values in the same cycle (async). No tri_done. A new box is accepted immediately after release.
- With BB_TRAVERSER_SERPENTINE_EN, box 0..3 x 0..2 → (0,0),(1,0),(2,0),(2,1),(1,1),(0,1). pix_last on (0,1).
